alu_seq: RTL
============

# alu_seq

Parametrised, registered successor to the 84CP combinational adder/logic unit. Extends the four-function datapath to eight functions and adds registered Z/N/C/V flags. Adds multi-cycle logical shifts that move one bit per clock, which keeps the shifter small enough for the XC9572XL-class CPLD. Sits between the register file and the result bus and is driven by the microsequencer through a START/BUSY/DONE handshake.

## Interface
- WIDTH, 16, datapath width in bits (≥4).
- SHIFT_BITS, 4, width of shift count; must equal log2(WIDTH).
- Reset is synchronous and active-high. The block has one clock.
- CLK  in  1  sole clock; all state changes on rising edge.
- RESET  in  1  synchronous, active-high; sampled on CLK rising edge.
- START  in  1  request; sampled only in IDLE.
- FUNC  in  3  function select, latched with START.
- A  in  WIDTH  operand A, latched with START.
- B  in  WIDTH  operand B / shift count source, latched with START.
- C_IN  in  1  carry in, latched with START.
- OUT  out  WIDTH  registered result; holds until next completion.
- C_OUT  out  1  registered carry flag.
- Z  out  1  registered zero flag (OUT == 0).
- N  out  1  registered negative flag (OUT[WIDTH-1]).
- V  out  1  registered signed-overflow flag.
- BUSY  out  1  high while a multi-cycle shift is in progress.
- DONE  out  1  one-cycle pulse when OUT and flags have just been updated.

## Operation
- FUNC encoding:
  - 000 ADD: A+B+C_IN.
  - 001 SUB: A+~B+C_IN (C_IN=1 means no borrow).
  - 010 ANDN: A&~B.
  - 011 OR: A|B.
  - 100 NOTB: ~B.
  - 101 XOR: A^B.
  - 110 SHL: logical shift left.
  - 111 SHR: logical shift right.
- Arithmetic is computed at WIDTH+1 bits. C_OUT is bit WIDTH of the sum.
- V for ADD/SUB: the operand MSBs entering the adder (A and B, or A and ~B) are equal, and the result MSB differs from them.
- For logic functions, C_OUT=0 and V=0.
- For shifts:
  - Shift operand is A; count is B[SHIFT_BITS-1:0]; vacated bits fill with 0.
  - C_OUT is the last bit shifted out. For count 0, C_OUT=0 and OUT=A.
  - V=0.
- Z and N are always derived from the new OUT value.
- States are IDLE and SHIFT.
- IDLE + START + (FUNC≠SHL/SHR, or shift count 0):
  - Result and flags are registered at that edge.
  - DONE=1 for the following cycle.
  - State stays IDLE.
- IDLE + START + shift with count n≥1:
  - At that edge, latch A into the work register, set the counter to n, and set BUSY=1.
  - State goes to SHIFT.
  - OUT and flags do not change.
- SHIFT, each edge: shift the work register by one bit, record the bit shifted out, and decrement the counter.
- When the counter reaches 0:
  - OUT is written from the work register and the flags are written.
  - DONE=1 for the following cycle, BUSY=0, and state returns to IDLE.
- START while in SHIFT is ignored. No queuing, no error.
- START in a cycle where DONE=1 is accepted normally, since the state is already IDLE.
- RESET has priority over everything, including mid-shift. On reset:
  - State goes to IDLE and the in-flight operation is discarded.
  - OUT=0, C_OUT=0, Z=0, N=0, V=0, BUSY=0, DONE=0.
- Z is 0 after reset until the first completion, even though OUT=0.

## Timing
- Non-shift ops and count-0 shifts:
  - START is sampled at edge k.
  - OUT, flags and DONE are valid after edge k.
  - Throughput is one op per clock with START held high.
- Shift with count n≥1:
  - START at edge k; BUSY high after edge k.
  - Shifts occur at edges k+1 through k+n.
  - OUT, flags and DONE are valid after edge k+n, and BUSY is low after edge k+n.
- Maximum latency is WIDTH edges (n = WIDTH−1).
- DONE is exactly one cycle wide per accepted operation.
- BUSY and DONE are never high in the same cycle.
- Operand inputs may change freely after the START edge.

## Test plan
- ADD, WIDTH=16: A=0xFFFF, B=0x0001, C_IN=0.
  - Expect OUT=0x0000, C_OUT=1, Z=1, N=0, V=0.
  - DONE high exactly one cycle after the START edge; BUSY never high.
- SUB: A=0x8000, B=0x0001, C_IN=1.
  - Expect OUT=0x7FFF, C_OUT=1, V=1, N=0.
- ADD: A=0x7FFF, B=0x0001, C_IN=0.
  - Expect OUT=0x8000, V=1, N=1, C_OUT=0.
- Back-to-back over three consecutive START cycles: ANDN (0xF0F0, 0xFF00), then OR, then XOR.
  - Expect three consecutive DONE pulses with OUT=0x00F0, 0xFFF0, 0x0FF0.
- SHR: A=0x8001, B=0x0003.
  - BUSY is high for 3 cycles; a START asserted mid-shift is ignored.
  - Then OUT=0x1000, C_OUT=0, DONE pulse.
  - Then SHL: A=0xC000, count 1 → OUT=0x8000, C_OUT=1 after 1 shift edge.
- Reset mid-shift: SHL with count 15, RESET asserted after 5 cycles.
  - Next cycle all outputs are 0 and BUSY=0, with no DONE.
  - A following ADD 2+3 gives OUT=0x0005 with normal 1-cycle DONE.
  - A count-0 SHL gives OUT=A and DONE one cycle later.

Source files
------------

// File: rtl/alu_seq.sv
// Registered eight-function ALU with Z/N/C/V flags and a one-bit-per-clock logical shifter.
// Single-cycle ops complete at the START edge; shifts of n>=1 take n further edges.
module alu_seq #(
    parameter int WIDTH      = 16,
    parameter int SHIFT_BITS = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [2:0]       FUNC,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C_IN,
    output logic [WIDTH-1:0] OUT,
    output logic             C_OUT,
    output logic             Z,
    output logic             N,
    output logic             V,
    output logic             BUSY,
    output logic             DONE
);

    localparam logic [2:0] F_ADD  = 3'b000;
    localparam logic [2:0] F_SUB  = 3'b001;
    localparam logic [2:0] F_ANDN = 3'b010;
    localparam logic [2:0] F_OR   = 3'b011;
    localparam logic [2:0] F_NOTB = 3'b100;
    localparam logic [2:0] F_XOR  = 3'b101;
    localparam logic [2:0] F_SHL  = 3'b110;
    localparam logic [2:0] F_SHR  = 3'b111;

    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } state_t;

    state_t                state_q, state_d;
    logic [WIDTH-1:0]      work_q, work_d;
    logic [SHIFT_BITS-1:0] cnt_q, cnt_d;
    logic                  left_q, left_d;
    logic [WIDTH-1:0]      out_q, out_d;
    logic                  c_q, c_d;
    logic                  z_q, z_d;
    logic                  n_q, n_d;
    logic                  v_q, v_d;
    logic                  done_q, done_d;

    logic [WIDTH-1:0]      res;
    logic                  res_c;
    logic                  res_v;
    logic [WIDTH+1:0]      add_res;
    logic [WIDTH-1:0]      shifted;
    logic                  shift_bit;
    logic [SHIFT_BITS-1:0] cnt_in;
    logic                  is_shift;

    // Returns {overflow, carry, sum}; overflow uses the operand MSBs as they enter the adder.
    function automatic logic [WIDTH+1:0] add_with_flags(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic             cin
    );
        logic [WIDTH:0] sum;
        logic           ovf;
        sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        return {ovf, sum};
    endfunction

    assign cnt_in   = B[SHIFT_BITS-1:0];
    assign is_shift = (FUNC == F_SHL) || (FUNC == F_SHR);

    always_comb begin
        add_res = add_with_flags(A, (FUNC == F_SUB) ? ~B : B, C_IN);
        res     = A;
        res_c   = 1'b0;
        res_v   = 1'b0;
        case (FUNC)
            F_ADD, F_SUB: begin
                res   = add_res[WIDTH-1:0];
                res_c = add_res[WIDTH];
                res_v = add_res[WIDTH+1];
            end
            F_ANDN:  res = A & ~B;
            F_OR:    res = A | B;
            F_NOTB:  res = ~B;
            F_XOR:   res = A ^ B;
            default: res = A;  // count-0 shift passes A through
        endcase
    end

    always_comb begin
        shifted   = left_q ? {work_q[WIDTH-2:0], 1'b0} : {1'b0, work_q[WIDTH-1:1]};
        shift_bit = left_q ? work_q[WIDTH-1] : work_q[0];
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        left_d  = left_q;
        out_d   = out_q;
        c_d     = c_q;
        z_d     = z_q;
        n_d     = n_q;
        v_d     = v_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    if (is_shift && (cnt_in != '0)) begin
                        work_d  = A;
                        cnt_d   = cnt_in;
                        left_d  = (FUNC == F_SHL);
                        state_d = S_SHIFT;
                    end else begin
                        out_d  = res;
                        c_d    = res_c;
                        v_d    = res_v;
                        z_d    = (res == '0);
                        n_d    = res[WIDTH-1];
                        done_d = 1'b1;
                    end
                end
            end
            S_SHIFT: begin
                work_d = shifted;
                cnt_d  = cnt_q - SHIFT_BITS'(1);
                // The last shift edge also publishes the result.
                if (cnt_q == SHIFT_BITS'(1)) begin
                    out_d   = shifted;
                    c_d     = shift_bit;
                    v_d     = 1'b0;
                    z_d     = (shifted == '0);
                    n_d     = shifted[WIDTH-1];
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            left_q  <= 1'b0;
            out_q   <= '0;
            c_q     <= 1'b0;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
            v_q     <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            left_q  <= left_d;
            out_q   <= out_d;
            c_q     <= c_d;
            z_q     <= z_d;
            n_q     <= n_d;
            v_q     <= v_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge CLK) begin
        work_q <= work_d;
    end

    assign OUT   = out_q;
    assign C_OUT = c_q;
    assign Z     = z_q;
    assign N     = n_q;
    assign V     = v_q;
    assign BUSY  = (state_q == S_SHIFT);
    assign DONE  = done_q;

endmodule
